// File: rtl/mem_arbiter2_pkg.sv
// Shared types for the two-port memory arbiter: FSM encoding, port select,
// the request bundle that gets muxed onto the memory port, and timer sizing.
package mem_arbiter2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    localparam mem_req_t REQ_NONE = '0;

    // Wait counter must hold 0..timeout; a disabled timer still needs one bit.
    function automatic int timer_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Grant wait counter: cleared outside a grant, counts stalled grant cycles,
// saturates at TIMEOUT and flags hit there. TIMEOUT=0 never hits.
module mem_arb_timer
    import mem_arbiter2_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic hit
);

    localparam int            CW    = timer_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (TIMEOUT > 0) && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter2.sv
// Two-requester round-robin arbiter in front of a single valid/ready memory
// port, with a per-grant timeout that completes a stuck transfer with an error.
module mem_arbiter2
    import mem_arbiter2_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int A_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_valid,
    input  logic        a_instr,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_wstrb,
    output logic        a_ready,
    output logic        a_err,
    output logic [31:0] a_rdata,

    input  logic        b_valid,
    input  logic        b_instr,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_wstrb,
    output logic        b_ready,
    output logic        b_err,
    output logic [31:0] b_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    state_t   state;
    state_t   state_next;
    port_t    last_grant;
    logic     timeout_hit;
    logic     grant_a;
    logic     grant_b;
    mem_req_t a_req;
    mem_req_t b_req;
    mem_req_t sel_req;

    assign a_req = {a_instr, a_addr, a_wdata, a_wstrb};
    assign b_req = {b_instr, b_addr, b_wdata, b_wstrb};

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE),
        .tick  ((state != IDLE) && !mem_ready),
        .hit   (timeout_hit)
    );

    // State register; last_grant is captured on the IDLE -> GRANT transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= (A_FIRST != 0) ? PORT_B : PORT_A;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == GRANT_A) begin
                last_grant <= PORT_A;
            end else if (state == IDLE && state_next == GRANT_B) begin
                last_grant <= PORT_B;
            end
        end
    end

    // NOTE: default assignment first so no branch leaves state_next unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    state_next = (last_grant == PORT_A) ? GRANT_B : GRANT_A;
                end else if (a_valid) begin
                    state_next = GRANT_A;
                end else if (b_valid) begin
                    state_next = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!a_valid || mem_ready || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            GRANT_B: begin
                if (!b_valid || mem_ready || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are squashed while reset is high so an aborted grant never
    // completes, even though the state register still shows it this cycle.
    always_comb begin
        grant_a   = (state == GRANT_A) && !reset;
        grant_b   = (state == GRANT_B) && !reset;

        mem_valid = ((grant_a && a_valid) || (grant_b && b_valid)) && !timeout_hit;

        sel_req   = REQ_NONE;
        if (grant_a) begin
            sel_req = a_req;
        end else if (grant_b) begin
            sel_req = b_req;
        end
        mem_instr = sel_req.instr;
        mem_addr  = sel_req.addr;
        mem_wdata = sel_req.wdata;
        mem_wstrb = sel_req.wstrb;

        a_ready   = grant_a && ((mem_valid && mem_ready) || timeout_hit);
        b_ready   = grant_b && ((mem_valid && mem_ready) || timeout_hit);
        a_err     = grant_a && timeout_hit;
        b_err     = grant_b && timeout_hit;
        a_rdata   = (a_ready && !a_err) ? mem_rdata : 32'd0;
        b_rdata   = (b_ready && !b_err) ? mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2 (TIMEOUT=4, A_FIRST=1): inputs change and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_mem_arbiter2;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_instr, b_valid, b_instr;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_wstrb, b_wstrb;
    logic        a_ready, a_err, b_ready, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter2 #(
        .TIMEOUT (4),
        .A_FIRST (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_instr   (a_instr),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_wstrb   (a_wstrb),
        .a_ready   (a_ready),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_valid   (b_valid),
        .b_instr   (b_instr),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_wstrb   (b_wstrb),
        .b_ready   (b_ready),
        .b_err     (b_err),
        .b_rdata   (b_rdata),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        a_valid = 1'b0; a_instr = 1'b0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        b_valid = 1'b0; b_instr = 1'b0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mv"},    32'(mem_valid), 32'd0);
        check({tag, "_minst"}, 32'(mem_instr), 32'd0);
        check({tag, "_maddr"}, mem_addr,       32'd0);
        check({tag, "_mwd"},   mem_wdata,      32'd0);
        check({tag, "_mws"},   32'(mem_wstrb), 32'd0);
        check({tag, "_ardy"},  32'(a_ready),   32'd0);
        check({tag, "_brdy"},  32'(b_ready),   32'd0);
        check({tag, "_aerr"},  32'(a_err),     32'd0);
        check({tag, "_berr"},  32'(b_err),     32'd0);
        check({tag, "_ard"},   a_rdata,        32'd0);
        check({tag, "_brd"},   b_rdata,        32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; clear_inputs();
        @(negedge clk); reset = 1'b0; #1;
        check_zero("rst_after");
    endtask

    // Single requester, memory never answers: err on the 5th grant cycle.
    task automatic timeout_case(input logic use_a, input string tag);
        @(negedge clk);
        a_valid = use_a; b_valid = !use_a;
        a_addr = 32'h0000_0A00; b_addr = 32'h0000_0B00;
        mem_ready = 1'b0; mem_rdata = 32'hCAFE_F00D;
        #1 check({tag, "_idle_mv"}, 32'(mem_valid), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #1;
            if (c < 5) begin
                check({tag, "_wait_mv"},  32'(mem_valid), 32'd1);
                check({tag, "_wait_ar"},  32'(a_ready),   32'd0);
                check({tag, "_wait_br"},  32'(b_ready),   32'd0);
                check({tag, "_wait_ae"},  32'(a_err),     32'd0);
                check({tag, "_wait_be"},  32'(b_err),     32'd0);
            end else begin
                check({tag, "_to_mv"}, 32'(mem_valid), 32'd0);
                check({tag, "_to_ar"}, 32'(a_ready),   32'(use_a));
                check({tag, "_to_ae"}, 32'(a_err),     32'(use_a));
                check({tag, "_to_br"}, 32'(b_ready),   32'(!use_a));
                check({tag, "_to_be"}, 32'(b_err),     32'(!use_a));
                check({tag, "_to_ad"}, a_rdata,        32'd0);
                check({tag, "_to_bd"}, b_rdata,        32'd0);
            end
        end
        @(negedge clk); a_valid = 1'b0; b_valid = 1'b0; #1;
        check({tag, "_after_mv"}, 32'(mem_valid), 32'd0);
        check({tag, "_after_ae"}, 32'(a_err),     32'd0);
        check({tag, "_after_be"}, 32'(b_err),     32'd0);
    endtask

    always @(negedge clk) begin
        #3 check("one_hot_ready", 32'(a_ready & b_ready), 32'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        check_zero("rst_during");
        do_reset();

        // Single A read, memory answers two cycles after mem_valid.
        @(negedge clk);
        a_valid = 1'b1; a_addr = 32'h0000_0100; a_wstrb = 4'h0;
        #1 check("t1_idle_mv", 32'(mem_valid), 32'd0);
        @(negedge clk); #1;
        check("t1_mv",    32'(mem_valid), 32'd1);
        check("t1_maddr", mem_addr,       32'h0000_0100);
        check("t1_mws",   32'(mem_wstrb), 32'd0);
        check("t1_ar0",   32'(a_ready),   32'd0);
        @(negedge clk); #1;
        check("t1_mv2",   32'(mem_valid), 32'd1);
        check("t1_ar1",   32'(a_ready),   32'd0);
        @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        check("t1_ar",    32'(a_ready),   32'd1);
        check("t1_ard",   a_rdata,        32'hDEAD_BEEF);
        check("t1_ae",    32'(a_err),     32'd0);
        check("t1_br",    32'(b_ready),   32'd0);
        check("t1_brd",   b_rdata,        32'd0);
        // mem_ready held high in IDLE must not complete anything.
        @(negedge clk); a_valid = 1'b0; #1;
        check("t1_idle_rdy_mv", 32'(mem_valid), 32'd0);
        check("t1_idle_rdy_ar", 32'(a_ready),   32'd0);
        check("t1_idle_rdy_br", 32'(b_ready),   32'd0);
        mem_ready = 1'b0;

        // Simultaneous requests from reset: A first, B two cycles after a_ready.
        do_reset();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 32'h0000_0200;
        b_valid = 1'b1; b_addr = 32'h0000_0300; b_wdata = 32'h1234_5678;
        b_wstrb = 4'hF; b_instr = 1'b1;
        @(negedge clk); #1;
        check("t2_a_mv",    32'(mem_valid), 32'd1);
        check("t2_a_maddr", mem_addr,       32'h0000_0200);
        check("t2_a_minst", 32'(mem_instr), 32'd0);
        @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h0000_1111; #1;
        check("t2_a_rdy",   32'(a_ready),   32'd1);
        check("t2_a_brdy",  32'(b_ready),   32'd0);
        @(negedge clk); a_valid = 1'b0; mem_ready = 1'b0; #1;
        check("t2_gap_mv",  32'(mem_valid), 32'd0);
        @(negedge clk); #1;
        check("t2_b_mv",    32'(mem_valid), 32'd1);
        check("t2_b_maddr", mem_addr,       32'h0000_0300);
        check("t2_b_mwd",   mem_wdata,      32'h1234_5678);
        check("t2_b_mws",   32'(mem_wstrb), 32'h0000_000F);
        check("t2_b_minst", 32'(mem_instr), 32'd1);
        check("t2_b_brdy0", 32'(b_ready),   32'd0);
        @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h0000_55AA; #1;
        check("t2_b_rdy",   32'(b_ready),   32'd1);
        check("t2_b_rd",    b_rdata,        32'h0000_55AA);
        check("t2_b_ardy",  32'(a_ready),   32'd0);
        @(negedge clk); b_valid = 1'b0; b_instr = 1'b0; mem_ready = 1'b0;

        // Both held continuously: grants must alternate A, B, A.
        @(negedge clk);
        a_valid = 1'b1; a_addr = 32'h0000_0400;
        b_valid = 1'b1; b_addr = 32'h0000_0500;
        #1 check("t3_idle_mv", 32'(mem_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            logic exp_a;
            exp_a = (k % 2 == 0);
            @(negedge clk); mem_ready = 1'b1; #1;
            check("t3_mv",    32'(mem_valid), 32'd1);
            check("t3_maddr", mem_addr,       exp_a ? 32'h0000_0400 : 32'h0000_0500);
            check("t3_ardy",  32'(a_ready),   32'(exp_a));
            check("t3_brdy",  32'(b_ready),   32'(!exp_a));
            @(negedge clk); mem_ready = 1'b0;
            if (k == 2) begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
            #1 check("t3_gap_mv", 32'(mem_valid), 32'd0);
        end

        // Timeout on both ports (last grant was A, so B's case goes first).
        timeout_case(1'b0, "t4b");
        timeout_case(1'b1, "t4a");

        // Reset one cycle into GRANT_A aborts silently.
        @(negedge clk); a_valid = 1'b1; a_addr = 32'h0000_0700;
        #1 check("t5_idle_mv", 32'(mem_valid), 32'd0);
        @(negedge clk); #1;
        check("t5_grant_mv", 32'(mem_valid), 32'd1);
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h7777_7777; #1;
        check_zero("t5_in_rst");
        @(negedge clk); reset = 1'b0; a_valid = 1'b0; mem_ready = 1'b0; #1;
        check_zero("t5_post_rst");
        @(negedge clk); #1;
        check("t5_quiet_mv", 32'(mem_valid), 32'd0);
        a_valid = 1'b1;
        @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h0000_0707; #1;
        check("t5_new_mv",    32'(mem_valid), 32'd1);
        check("t5_new_maddr", mem_addr,       32'h0000_0700);
        check("t5_new_ardy",  32'(a_ready),   32'd1);
        check("t5_new_ard",   a_rdata,        32'h0000_0707);
        @(negedge clk); a_valid = 1'b0; mem_ready = 1'b0;

        // A drops valid mid-grant; pending B is then served, not preempted earlier.
        @(negedge clk); a_valid = 1'b1; a_addr = 32'h0000_0800; b_addr = 32'h0000_0900;
        #1 check("t6_idle_mv", 32'(mem_valid), 32'd0);
        @(negedge clk); b_valid = 1'b1; #1;
        check("t6_a_mv",    32'(mem_valid), 32'd1);
        check("t6_a_maddr", mem_addr,       32'h0000_0800);
        @(negedge clk); #1;
        check("t6_nopre_maddr", mem_addr,     32'h0000_0800);
        check("t6_nopre_brdy",  32'(b_ready), 32'd0);
        a_valid = 1'b0; #1;
        check("t6_drop_mv",  32'(mem_valid), 32'd0);
        check("t6_drop_ar",  32'(a_ready),   32'd0);
        check("t6_drop_ae",  32'(a_err),     32'd0);
        @(negedge clk); #1;
        check("t6_idle2_mv", 32'(mem_valid), 32'd0);
        @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h0000_0909; #1;
        check("t6_b_mv",    32'(mem_valid), 32'd1);
        check("t6_b_maddr", mem_addr,       32'h0000_0900);
        check("t6_b_rdy",   32'(b_ready),   32'd1);
        check("t6_b_rd",    b_rdata,        32'h0000_0909);
        @(negedge clk); b_valid = 1'b0; mem_ready = 1'b0; #1;
        check("t6_end_mv",  32'(mem_valid), 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
